// File: rtl/vc_router_pkg.sv
// Shared flit-type encoding and arbiter state definitions for the VC router blocks.
package vc_router_pkg;

   // Flit type field values, carried in bits [30:29] of every flit.
   localparam logic [1:0] FLIT_HEAD   = 2'b01;
   localparam logic [1:0] FLIT_BODY   = 2'b00;
   localparam logic [1:0] FLIT_TAIL   = 2'b11;
   localparam logic [1:0] FLIT_SINGLE = 2'b10;

   localparam int FLIT_TYPE_MSB = 30;
   localparam int FLIT_TYPE_LSB = 29;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // A flit that may legally open a packet (and therefore request the link).
   function automatic logic is_pkt_start(input logic [1:0] flit_type);
      return (flit_type == FLIT_HEAD) || (flit_type == FLIT_SINGLE);
   endfunction

   // A flit that closes a packet and releases the wormhole lock.
   function automatic logic is_pkt_end(input logic [1:0] flit_type);
      return (flit_type == FLIT_TAIL) || (flit_type == FLIT_SINGLE);
   endfunction

endpackage

// File: rtl/vc_output_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after the pointer,
// wrapping modulo N. Also used by the VC allocator.
module rr_pick import vc_router_pkg::*; #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          valid
);

   logic [PW-1:0] idx;

   // Walk the N candidates starting at ptr+1 and keep the first one that requests.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = ptr;
      for (int k = 0; k < N; k++) begin
         idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vc_output_arbiter.sv
// Output-link arbiter: grants the link to one VC FIFO for a whole packet
// (wormhole lock), round-robin between packets, and discards orphan flits.
module vc_output_arbiter import vc_router_pkg::*; #(
   parameter int NUM_VC = 4,
   parameter int DW     = 32,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_VC-1:0]    vc_empty,
   input  logic [NUM_VC*DW-1:0] vc_data,
   output logic [NUM_VC-1:0]    vc_rd,
   input  logic                 out_full,
   output logic                 out_val,
   output logic [DW-1:0]        out_data,
   output logic [NUM_VC-1:0]    grant,
   output logic                 busy,
   output logic                 err_drop,
   output logic [CNT_W-1:0]     pkt_cnt
);

   localparam int PW = $clog2(NUM_VC);

   arb_state_e        state_reg, state_next;
   logic [NUM_VC-1:0] grant_reg, grant_next;
   logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
   logic              out_val_reg, out_val_next;
   logic [DW-1:0]     out_data_reg, out_data_next;
   logic              err_drop_reg, err_drop_next;
   logic [CNT_W-1:0]  pkt_cnt_reg, pkt_cnt_next;

   logic [DW-1:0]     head_data [NUM_VC];
   logic [1:0]        head_type [NUM_VC];
   logic [NUM_VC-1:0] req;
   logic [NUM_VC-1:0] orphan;
   logic [NUM_VC-1:0] drop_onehot;
   logic [NUM_VC-1:0] pick_onehot;
   logic              pick_valid;
   logic [NUM_VC-1:0] rd_comb;
   logic [PW-1:0]     gidx;

   // Per-VC decode of the head flit into request / orphan flags.
   generate
      for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
         assign head_data[gi] = vc_data[gi*DW +: DW];
         assign head_type[gi] = head_data[gi][FLIT_TYPE_MSB:FLIT_TYPE_LSB];
         assign req[gi]       = !vc_empty[gi] &&  is_pkt_start(head_type[gi]);
         assign orphan[gi]    = !vc_empty[gi] && !is_pkt_start(head_type[gi]);
      end
   endgenerate

   // Two's-complement trick isolates the lowest-index orphan.
   assign drop_onehot = orphan & (~orphan + 1'b1);

   rr_pick #(
      .N  (NUM_VC),
      .PW (PW)
   ) u_rr_pick (
      .req    (req),
      .ptr    (rr_ptr_reg),
      .winner (pick_onehot),
      .valid  (pick_valid)
   );

   // Encode the one-hot grant into an index for the data/empty muxes.
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (grant_reg[i]) gidx = PW'(i);
      end
   end

   // Next-state and read-strobe logic for the IDLE/LOCKED wormhole FSM.
   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      rr_ptr_next   = rr_ptr_reg;
      out_val_next  = 1'b0;
      out_data_next = out_data_reg;
      err_drop_next = 1'b0;
      pkt_cnt_next  = pkt_cnt_reg;
      rd_comb       = '0;
      case (state_reg)
         IDLE: begin
            // Arbitration cycle never pops; an orphan is only dropped when no packet waits.
            if (pick_valid) begin
               state_next = LOCKED;
               grant_next = pick_onehot;
            end else if (|orphan) begin
               rd_comb       = drop_onehot;
               err_drop_next = 1'b1;
            end
         end
         LOCKED: begin
            // Empty FIFO or downstream full simply holds the lock; there is no timeout.
            if (!vc_empty[gidx] && !out_full) begin
               rd_comb       = grant_reg;
               out_val_next  = 1'b1;
               out_data_next = head_data[gidx];
               if (is_pkt_end(head_type[gidx])) begin
                  state_next   = IDLE;
                  grant_next   = '0;
                  rr_ptr_next  = gidx;
                  pkt_cnt_next = pkt_cnt_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously by the active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         grant_reg    <= '0;
         rr_ptr_reg   <= PW'(NUM_VC - 1);
         out_val_reg  <= 1'b0;
         out_data_reg <= '0;
         err_drop_reg <= 1'b0;
         pkt_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         rr_ptr_reg   <= rr_ptr_next;
         out_val_reg  <= out_val_next;
         out_data_reg <= out_data_next;
         err_drop_reg <= err_drop_next;
         pkt_cnt_reg  <= pkt_cnt_next;
      end
   end

   // Strobes are forced low while reset is held so no FIFO pops during reset.
   assign vc_rd    = reset ? rd_comb : '0;
   assign out_val  = out_val_reg;
   assign out_data = out_data_reg;
   assign grant    = grant_reg;
   assign busy     = (state_reg == LOCKED);
   assign err_drop = err_drop_reg;
   assign pkt_cnt  = pkt_cnt_reg;

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Self-checking bench for vc_output_arbiter: FIFO contents are bench queues,
// expectations come from a packet-level reference model of the arbitration rules.
module tb_vc_output_arbiter;

   localparam int NUM_VC = 4;
   localparam int DW     = 32;
   // Narrow counter so the wrap-around can be reached in a short run.
   localparam int CNT_W  = 8;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [NUM_VC-1:0]    vc_empty = '1;
   logic [NUM_VC*DW-1:0] vc_data = '0;
   logic [NUM_VC-1:0]    vc_rd;
   logic                 out_full = 1'b0;
   logic                 out_val;
   logic [DW-1:0]        out_data;
   logic [NUM_VC-1:0]    grant;
   logic                 busy;
   logic                 err_drop;
   logic [CNT_W-1:0]     pkt_cnt;

   vc_output_arbiter #(.NUM_VC(NUM_VC), .DW(DW), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .vc_empty (vc_empty),
      .vc_data  (vc_data),
      .vc_rd    (vc_rd),
      .out_full (out_full),
      .out_val  (out_val),
      .out_data (out_data),
      .grant    (grant),
      .busy     (busy),
      .err_drop (err_drop),
      .pkt_cnt  (pkt_cnt)
   );

   always #5 clk = ~clk;

   // FIFO contents and reference-model state.
   logic [DW-1:0] q [NUM_VC][$];
   logic [DW-1:0] sent [$];
   bit            m_locked;
   int            m_owner, m_last, m_pkt, n_drops;
   bit            m_val, m_err;
   logic [DW-1:0] m_data;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [28:0] payload);
      return {1'b0, t, payload};
   endfunction

   function automatic bit opens(input logic [DW-1:0] f);
      return (f[30:29] == 2'b01) || (f[30:29] == 2'b10);
   endfunction

   function automatic bit closes(input logic [DW-1:0] f);
      return (f[30:29] == 2'b11) || (f[30:29] == 2'b10);
   endfunction

   function automatic bit pending();
      bit p;
      p = m_locked;
      for (int i = 0; i < NUM_VC; i++) if (q[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic model_reset();
      m_locked = 1'b0; m_owner = 0; m_last = NUM_VC - 1; m_pkt = 0;
      m_val = 1'b0; m_err = 1'b0; m_data = '0;
   endtask

   // Push a well-formed packet of len flits (1 = single flit).
   task automatic push_pkt(input int vc, input int len);
      if (len == 1) q[vc].push_back(mk(2'b10, 29'($urandom)));
      else begin
         q[vc].push_back(mk(2'b01, 29'($urandom)));
         for (int k = 0; k < len - 2; k++) q[vc].push_back(mk(2'b00, 29'($urandom)));
         q[vc].push_back(mk(2'b11, 29'($urandom)));
      end
   endtask

   // One clock cycle: drive FIFO heads, check strobes, advance model, check registers.
   task automatic step(input logic full);
      logic [NUM_VC-1:0] e_rd;
      logic [NUM_VC-1:0] e_grant;
      int w, drop, idx;
      logic [DW-1:0] f;
      out_full = full;
      for (int i = 0; i < NUM_VC; i++) begin
         vc_empty[i] = (q[i].size() == 0);
         vc_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : DW'($urandom);
      end
      #1;
      e_rd = '0; w = -1; drop = -1;
      if (!m_locked) begin
         for (int k = 1; k <= NUM_VC; k++) begin
            idx = (m_last + k) % NUM_VC;
            if (w < 0 && q[idx].size() != 0 && opens(q[idx][0])) w = idx;
         end
         if (w < 0) begin
            for (int i = NUM_VC - 1; i >= 0; i--)
               if (q[i].size() != 0 && !opens(q[i][0])) drop = i;
            if (drop >= 0) e_rd[drop] = 1'b1;
         end
      end else if (q[m_owner].size() != 0 && !full) begin
         e_rd[m_owner] = 1'b1;
      end
      check("vc_rd", 64'(vc_rd), 64'(e_rd));
      @(posedge clk);
      m_err = 1'b0; m_val = 1'b0;
      if (!m_locked) begin
         if (w >= 0) begin m_locked = 1'b1; m_owner = w; end
         else if (drop >= 0) begin q[drop].delete(0); m_err = 1'b1; n_drops++; end
      end else if (e_rd != '0) begin
         f = q[m_owner].pop_front();
         m_val = 1'b1; m_data = f; sent.push_back(f);
         if (closes(f)) begin
            m_locked = 1'b0; m_last = m_owner; m_pkt = (m_pkt + 1) % (1 << CNT_W);
         end
      end
      #1;
      e_grant = '0;
      if (m_locked) e_grant[m_owner] = 1'b1;
      check("out_val", 64'(out_val), 64'(m_val));
      check("out_data", 64'(out_data), 64'(m_data));
      check("grant", 64'(grant), 64'(e_grant));
      check("busy", 64'(busy), 64'(m_locked));
      check("err_drop", 64'(err_drop), 64'(m_err));
      check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
      @(negedge clk);
   endtask

   task automatic drain(input int max_cycles, input int full_pct);
      int c;
      c = 0;
      while (pending() && c < max_cycles) begin
         step(($urandom % 100) < full_pct);
         c++;
      end
      if (c >= max_cycles) check("drain_timeout", 64'(c), 64'(0));
   endtask

   initial begin
      logic [DW-1:0] s0, s2, s0b, h, b, t;
      int need, pushed, sent_base, lone, drops_base;
      model_reset();
      n_drops = 0;

      // Reset state, with an orphan presented to prove strobes stay low in reset.
      repeat (2) @(negedge clk);
      vc_empty = 4'b1110;
      vc_data  = '0;
      #1;
      check("rst_vc_rd", 64'(vc_rd), 64'(0));
      check("rst_grant", 64'(grant), 64'(0));
      check("rst_out_val", 64'(out_val), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_err_drop", 64'(err_drop), 64'(0));
      check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      @(negedge clk);
      vc_empty = '1;
      reset = 1'b1;
      @(negedge clk);

      // Simultaneous singles on VC0/VC2, then VC0 again: order VC0, VC2, VC0.
      s0 = mk(2'b10, 29'h10); s2 = mk(2'b10, 29'h12); s0b = mk(2'b10, 29'h20);
      q[0].push_back(s0); q[2].push_back(s2);
      step(1'b0);
      step(1'b0);
      q[0].push_back(s0b);
      drain(50, 0);
      check("rot_count", 64'(sent.size()), 64'(3));
      if (sent.size() == 3) begin
         check("rot_first", 64'(sent[0]), 64'(s0));
         check("rot_second", 64'(sent[1]), 64'(s2));
         check("rot_third", 64'(sent[2]), 64'(s0b));
      end
      $display("txn rotation: %0d flits sent, pkt_cnt=%0d", sent.size(), pkt_cnt);

      // Three-flit packet on VC1.
      sent.delete();
      q[1].push_back(32'h2000_0001); q[1].push_back(32'h0000_0002); q[1].push_back(32'h6000_0003);
      step(1'b0);
      check("vc1_grant", 64'(grant), 64'(4'b0010));
      drain(50, 0);
      check("vc1_count", 64'(sent.size()), 64'(3));
      if (sent.size() == 3) begin
         check("vc1_head", 64'(sent[0]), 64'(32'h2000_0001));
         check("vc1_body", 64'(sent[1]), 64'(32'h0000_0002));
         check("vc1_tail", 64'(sent[2]), 64'(32'h6000_0003));
      end
      check("vc1_pkt_cnt", 64'(pkt_cnt), 64'(4));
      check("vc1_grant_idle", 64'(grant), 64'(0));
      $display("txn vc1 packet: pkt_cnt=%0d", pkt_cnt);

      // VC3 packet stalled by out_full for 4 cycles after the head.
      sent.delete();
      h = mk(2'b01, 29'h31); b = mk(2'b00, 29'h32); t = mk(2'b11, 29'h33);
      q[3].push_back(h); q[3].push_back(b); q[3].push_back(t);
      step(1'b0);
      step(1'b0);
      repeat (4) step(1'b1);
      drain(50, 0);
      check("stall_count", 64'(sent.size()), 64'(3));
      if (sent.size() == 3) begin
         check("stall_head", 64'(sent[0]), 64'(h));
         check("stall_body", 64'(sent[1]), 64'(b));
         check("stall_tail", 64'(sent[2]), 64'(t));
      end
      $display("txn vc3 stall: %0d flits sent", sent.size());

      // Orphan body flit on VC2 while idle.
      sent.delete();
      q[2].push_back(32'h0000_00AA);
      step(1'b0);
      check("orphan_err", 64'(err_drop), 64'(1));
      check("orphan_val", 64'(out_val), 64'(0));
      step(1'b0);
      check("orphan_err_clear", 64'(err_drop), 64'(0));
      check("orphan_pkt_cnt", 64'(pkt_cnt), 64'(5));
      check("orphan_sent", 64'(sent.size()), 64'(0));
      $display("txn orphan drop: drops=%0d", n_drops);

      // Reset in the middle of a VC1 packet.
      push_pkt(1, 3);
      repeat (3) step(1'b0);
      reset = 1'b0;
      #1;
      check("midrst_grant", 64'(grant), 64'(0));
      check("midrst_out_val", 64'(out_val), 64'(0));
      check("midrst_pkt_cnt", 64'(pkt_cnt), 64'(0));
      check("midrst_vc_rd", 64'(vc_rd), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      @(negedge clk);
      for (int i = 0; i < NUM_VC; i++) q[i].delete();
      vc_empty = '1;
      model_reset();
      reset = 1'b1;
      sent.delete();
      push_pkt(1, 3);
      drain(50, 0);
      check("postrst_count", 64'(sent.size()), 64'(3));
      check("postrst_pkt_cnt", 64'(pkt_cnt), 64'(1));
      $display("txn reset mid-packet: recovered pkt_cnt=%0d", pkt_cnt);

      // Randomized traffic with backpressure and occasional orphans.
      sent.delete();
      pushed = 0; lone = 0; drops_base = n_drops;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         for (int i = 0; i < NUM_VC; i++) begin
            if (q[i].size() < 6 && ($urandom % 16) == 0) begin
               int len;
               len = 1 + int'($urandom % 4);
               push_pkt(i, len);
               pushed += len;
            end else if (($urandom % 64) == 0) begin
               q[i].push_back(mk(($urandom % 2) ? 2'b11 : 2'b00, 29'($urandom)));
               lone++;
            end
         end
         step(($urandom % 4) == 0);
      end
      drain(2000, 25);
      check("rand_flits", 64'(sent.size()), 64'(pushed));
      check("rand_drops", 64'(n_drops - drops_base), 64'(lone));
      $display("txn random: %0d flits sent, %0d orphans dropped", sent.size(), n_drops - drops_base);

      // Counter wrap: bring pkt_cnt to its maximum, then one more packet.
      need = ((1 << CNT_W) - 1) - m_pkt;
      for (int k = 0; k < need; k++) push_pkt(k % NUM_VC, 1);
      drain(need * 3 + 50, 0);
      check("wrap_max", 64'(pkt_cnt), 64'((1 << CNT_W) - 1));
      push_pkt(2, 1);
      drain(50, 0);
      check("wrap_zero", 64'(pkt_cnt), 64'(0));
      $display("txn wrap: pkt_cnt=%0d", pkt_cnt);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
